// File: rtl/sram_bridge.sv
// Bridges a single-outstanding mem_req/mem_resp pair onto a 32-bit asynchronous SRAM.
// A wait-state FSM drives registered strobes: SETUP, ACCESS (WAIT_CYCLES), HOLD (writes only), RESP.
module sram_bridge #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] USED_ADDR = ((32'd1 << ADDR_W) - 32'd1) << 2;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;

  state_t           state;
  logic             is_write;
  logic [CNT_W-1:0] count;
  logic             unused_addr_bits;

  assign req_ready = (state == IDLE);
  // Byte-offset bits and bits above the SRAM range are intentionally dropped (aliasing).
  assign unused_addr_bits = ^(req_addr & ~USED_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      sram_addr  <= '0;
      sram_dq_o  <= 32'h0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Strobes are loaded here so they are already valid during SETUP.
            is_write  <= req_we;
            sram_addr <= req_addr[ADDR_W+1:2];
            sram_ce_n <= 1'b0;
            if (req_we) begin
              sram_dq_oe <= 1'b1;
              sram_dq_o  <= req_wdata;
              sram_be_n  <= ~req_be;
              sram_oe_n  <= 1'b1;
            end else begin
              sram_dq_oe <= 1'b0;
              sram_be_n  <= 4'h0;
              sram_oe_n  <= 1'b0;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          count <= CNT_LOAD;
          if (is_write) begin
            sram_we_n <= 1'b0;
          end
          state <= ACCESS;
        end
        ACCESS: begin
          if (count == '0) begin
            if (is_write) begin
              sram_we_n <= 1'b1;
              state     <= HOLD;
            end else begin
              resp_data  <= sram_dq_i;
              resp_valid <= 1'b1;
              sram_ce_n  <= 1'b1;
              sram_oe_n  <= 1'b1;
              sram_be_n  <= 4'hF;
              state      <= RESP;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        HOLD: begin
          // Address, data and ce_n stay put one cycle past we_n rising for data hold.
          resp_data  <= 32'h0;
          resp_valid <= 1'b1;
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_be_n  <= 4'hF;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
